// File: rtl/watch_pkg.sv
// Shared constants for the stopwatch APB sequencer: register map, CTRL bits,
// FSM and request encodings.
package watch_pkg;

  localparam logic [15:0] ADDR_CTRL     = 16'h0000;
  localparam logic [15:0] ADDR_CURR     = 16'h0004;
  localparam logic [15:0] ADDR_LAP_BASE = 16'h0010;

  // CTRL is write-only; each bit is a one-shot command to the watch
  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_RESET = 2;
  localparam int CTRL_STORE = 3;

  localparam logic [3:0] LAP_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_st_e;

  // Request sources, listed in arbitration priority order
  typedef enum logic [1:0] {
    REQ_RUN   = 2'd0,
    REQ_LAP   = 2'd1,
    REQ_LAPRD = 2'd2,
    REQ_POLL  = 2'd3
  } req_e;

  function automatic logic [31:0] ctrl_word(input int bitpos);
    return 32'd1 << bitpos;
  endfunction

  function automatic logic [15:0] lap_addr(input logic [3:0] n);
    return ADDR_LAP_BASE + {10'd0, n, 2'b00};
  endfunction

endpackage

// File: rtl/watch_poll_tmr.sv
// Free-running poll interval timer; one-cycle tick at terminal count.
// A zero interval parks the counter and never ticks.
module watch_poll_tmr #(
  parameter logic [15:0] POLL_CYCLES = 16'd1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        term;

  assign term   = (POLL_CYCLES != 16'd0) && (cnt_q == POLL_CYCLES - 16'd1);
  assign tick_o = term;

  // next count: wrap at terminal count, hold when disabled
  always_comb begin
    cnt_d = cnt_q;
    if (POLL_CYCLES != 16'd0) cnt_d = term ? 16'd0 : cnt_q + 16'd1;
  end

  // counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/watch_apb_seq.sv
// APB master sequencer for the stopwatch slave. Button pulses become CTRL
// writes, a timer drives CURR polls, and lap requests read LAPn. One transfer
// at a time with fixed-priority arbitration; bus outputs are registered.
module watch_apb_seq
  import watch_pkg::*;
#(
  parameter logic [15:0] POLL_CYCLES = 16'd1000,
  parameter logic [7:0]  TIMEOUT     = 8'd64
) (
  input  logic        iPCLK,
  input  logic        iPRESETn,
  input  logic        iBTN_RUN,
  input  logic        iBTN_LAP,
  input  logic        iLAP_REQ,
  input  logic [3:0]  iLAP_SEL,
  output logic        oPSEL,
  output logic        oPENABLE,
  output logic        oPWRITE,
  output logic [3:0]  oPSTRB,
  output logic [15:0] oPADDR,
  output logic [31:0] oPWDATA,
  input  logic [31:0] iPRDATA,
  input  logic        iPREADY,
  input  logic        iPSLVERR,
  output logic [31:0] oDISP_TIME,
  output logic        oDISP_VALID,
  output logic [31:0] oLAP_DATA,
  output logic        oLAP_VALID,
  output logic        oRUNNING,
  output logic        oERR,
  output logic        oBUSY
);

  apb_st_e     state_q, state_d;
  req_e        gnt_q, gnt_d;
  logic [7:0]  to_q, to_d;
  logic        run_q, run_d, lap_q, lap_d, lrd_q, lrd_d, poll_q, poll_d;
  logic [3:0]  sel_q, sel_d;
  logic        running_q, running_d, err_q, err_d;
  logic        psel_q, psel_d, pen_q, pen_d, pwr_q, pwr_d;
  logic [3:0]  strb_q, strb_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] disp_q, disp_d, lapd_q, lapd_d;
  logic        dvld_q, dvld_d, lvld_q, lvld_d;
  logic        tick, done, ok, abort, fin, any_pend;

  watch_poll_tmr #(.POLL_CYCLES(POLL_CYCLES)) u_tmr (
    .clk_i  (iPCLK),
    .rst_ni (iPRESETn),
    .tick_o (tick)
  );

  assign any_pend = run_q | lap_q | lrd_q | poll_q;
  assign done     = (state_q == ST_ACCESS) && iPREADY;
  assign ok       = done && !iPSLVERR;
  // ACCESS cycle number TIMEOUT with no ready is the last one we wait
  assign abort    = (state_q == ST_ACCESS) && !iPREADY && (to_q == TIMEOUT - 8'd1);
  assign fin      = done || abort;

  // next state: arbitrate in IDLE, fixed one-cycle SETUP, ACCESS until ready/timeout
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    to_d    = to_q;
    case (state_q)
      ST_IDLE: begin
        if (any_pend) begin
          state_d = ST_SETUP;
          if      (run_q) gnt_d = REQ_RUN;
          else if (lap_q) gnt_d = REQ_LAP;
          else if (lrd_q) gnt_d = REQ_LAPRD;
          else            gnt_d = REQ_POLL;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        to_d    = '0;
      end
      ST_ACCESS: begin
        if (fin) state_d = ST_IDLE;
        else     to_d    = to_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // bus outputs: load address/data on leaving IDLE, hold through ACCESS, zero when idle
  always_comb begin
    psel_d  = (state_d != ST_IDLE);
    pen_d   = (state_d == ST_ACCESS);
    pwr_d   = pwr_q;
    strb_d  = strb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_d == ST_IDLE) begin
      pwr_d   = 1'b0;
      strb_d  = 4'h0;
      addr_d  = '0;
      wdata_d = '0;
    end else if (state_q == ST_IDLE) begin
      pwr_d   = 1'b0;
      strb_d  = 4'h0;
      wdata_d = '0;
      case (gnt_d)
        REQ_RUN: begin
          pwr_d   = 1'b1;
          strb_d  = 4'hF;
          addr_d  = ADDR_CTRL;
          wdata_d = running_q ? ctrl_word(CTRL_STOP) : ctrl_word(CTRL_START);
        end
        REQ_LAP: begin
          pwr_d   = 1'b1;
          strb_d  = 4'hF;
          addr_d  = ADDR_CTRL;
          wdata_d = running_q ? ctrl_word(CTRL_STORE) : ctrl_word(CTRL_RESET);
        end
        REQ_LAPRD: addr_d = lap_addr(sel_q);
        default:   addr_d = ADDR_CURR;
      endcase
    end
  end

  // request flags, completion side effects and sticky error
  always_comb begin
    run_d     = run_q;
    lap_d     = lap_q;
    lrd_d     = lrd_q;
    poll_d    = poll_q;
    sel_d     = sel_q;
    running_d = running_q;
    err_d     = err_q;
    disp_d    = disp_q;
    lapd_d    = lapd_q;
    dvld_d    = 1'b0;
    lvld_d    = 1'b0;
    // the granted flag retires on any outcome
    if (fin) begin
      case (gnt_q)
        REQ_RUN:   run_d  = 1'b0;
        REQ_LAP:   lap_d  = 1'b0;
        REQ_LAPRD: lrd_d  = 1'b0;
        default:   poll_d = 1'b0;
      endcase
    end
    if ((done && iPSLVERR) || abort) err_d = 1'b1;
    if (ok) begin
      case (gnt_q)
        REQ_RUN:   running_d = ~running_q;
        REQ_LAPRD: begin lapd_d = iPRDATA; lvld_d = 1'b1; end
        REQ_POLL:  begin disp_d = iPRDATA; dvld_d = 1'b1; end
        default:   ;
      endcase
    end
    // a pulse only registers if its flag was clear before this edge
    if (iBTN_RUN && !run_q) run_d  = 1'b1;
    if (iBTN_LAP && !lap_q) lap_d  = 1'b1;
    if (tick && !poll_q)    poll_d = 1'b1;
    if (iLAP_REQ && !lrd_q) begin
      if (iLAP_SEL > LAP_MAX) err_d = 1'b1;
      else begin
        lrd_d = 1'b1;
        sel_d = iLAP_SEL;
      end
    end
  end

  // all sequencer state
  always_ff @(posedge iPCLK or negedge iPRESETn) begin
    if (!iPRESETn) begin
      state_q   <= ST_IDLE;
      gnt_q     <= REQ_RUN;
      to_q      <= '0;
      run_q     <= 1'b0;
      lap_q     <= 1'b0;
      lrd_q     <= 1'b0;
      poll_q    <= 1'b0;
      sel_q     <= '0;
      running_q <= 1'b0;
      err_q     <= 1'b0;
      psel_q    <= 1'b0;
      pen_q     <= 1'b0;
      pwr_q     <= 1'b0;
      strb_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      disp_q    <= '0;
      lapd_q    <= '0;
      dvld_q    <= 1'b0;
      lvld_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      to_q      <= to_d;
      run_q     <= run_d;
      lap_q     <= lap_d;
      lrd_q     <= lrd_d;
      poll_q    <= poll_d;
      sel_q     <= sel_d;
      running_q <= running_d;
      err_q     <= err_d;
      psel_q    <= psel_d;
      pen_q     <= pen_d;
      pwr_q     <= pwr_d;
      strb_q    <= strb_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      disp_q    <= disp_d;
      lapd_q    <= lapd_d;
      dvld_q    <= dvld_d;
      lvld_q    <= lvld_d;
    end
  end

  assign oPSEL       = psel_q;
  assign oPENABLE    = pen_q;
  assign oPWRITE     = pwr_q;
  assign oPSTRB      = strb_q;
  assign oPADDR      = addr_q;
  assign oPWDATA     = wdata_q;
  assign oDISP_TIME  = disp_q;
  assign oDISP_VALID = dvld_q;
  assign oLAP_DATA   = lapd_q;
  assign oLAP_VALID  = lvld_q;
  assign oRUNNING    = running_q;
  assign oERR        = err_q;
  assign oBUSY       = (state_q != ST_IDLE) | any_pend;

endmodule

// File: tb/tb_watch_apb_seq.sv
// Directed bench: u_dut (no polling, programmable slave) and u_poll
// (20-cycle polling, always-ready slave returning an incrementing time).
module tb_watch_apb_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- u_dut ----------------
  logic        d_run = 0, d_lap = 0, d_lreq = 0;
  logic [3:0]  d_sel = 0;
  logic        d_psel, d_pen, d_pwr, d_dispv, d_lapv, d_running, d_err, d_busy;
  logic [3:0]  d_strb;
  logic [15:0] d_addr;
  logic [31:0] d_wdata, d_disp, d_lapdat;
  logic [31:0] d_rdata = 0;
  logic        d_hang = 0, d_serr = 0;
  int          d_wait = 0, d_wcnt = 0;
  logic        d_pready;

  assign d_pready = !d_hang && (d_wcnt >= d_wait);
  always @(posedge clk)
    if (d_psel && d_pen && !d_pready) d_wcnt <= d_wcnt + 1;
    else                              d_wcnt <= 0;

  watch_apb_seq #(.POLL_CYCLES(16'd0), .TIMEOUT(8'd64)) u_dut (
    .iPCLK(clk), .iPRESETn(rst_n),
    .iBTN_RUN(d_run), .iBTN_LAP(d_lap), .iLAP_REQ(d_lreq), .iLAP_SEL(d_sel),
    .oPSEL(d_psel), .oPENABLE(d_pen), .oPWRITE(d_pwr), .oPSTRB(d_strb),
    .oPADDR(d_addr), .oPWDATA(d_wdata),
    .iPRDATA(d_rdata), .iPREADY(d_pready), .iPSLVERR(d_serr),
    .oDISP_TIME(d_disp), .oDISP_VALID(d_dispv),
    .oLAP_DATA(d_lapdat), .oLAP_VALID(d_lapv),
    .oRUNNING(d_running), .oERR(d_err), .oBUSY(d_busy)
  );

  // ---------------- u_poll ----------------
  logic        p_run = 0, p_lap = 0, p_lreq = 0;
  logic [3:0]  p_sel = 0;
  logic        p_psel, p_pen, p_pwr, p_dispv, p_lapv, p_running, p_err, p_busy;
  logic [3:0]  p_strb;
  logic [15:0] p_addr;
  logic [31:0] p_wdata, p_disp, p_lapdat;
  logic [31:0] p_time = 32'h100;

  always @(posedge clk) if (p_psel && p_pen) p_time <= p_time + 32'd1;

  watch_apb_seq #(.POLL_CYCLES(16'd20), .TIMEOUT(8'd64)) u_poll (
    .iPCLK(clk), .iPRESETn(rst_n),
    .iBTN_RUN(p_run), .iBTN_LAP(p_lap), .iLAP_REQ(p_lreq), .iLAP_SEL(p_sel),
    .oPSEL(p_psel), .oPENABLE(p_pen), .oPWRITE(p_pwr), .oPSTRB(p_strb),
    .oPADDR(p_addr), .oPWDATA(p_wdata),
    .iPRDATA(p_time), .iPREADY(1'b1), .iPSLVERR(1'b0),
    .oDISP_TIME(p_disp), .oDISP_VALID(p_dispv),
    .oLAP_DATA(p_lapdat), .oLAP_VALID(p_lapv),
    .oRUNNING(p_running), .oERR(p_err), .oBUSY(p_busy)
  );

  // ---------------- transfer logs ----------------
  typedef struct {
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [3:0]  strb;
    int          gap;
  } xfer_t;

  xfer_t dlog[$];
  xfer_t plog[$];
  xfer_t de, pe;
  int d_end = 0, p_end = 0, d_acc = 0, d_lapv_n = 0;

  // record each SETUP cycle and the distance from the previous completion
  always @(negedge clk) begin
    if (d_psel && !d_pen) begin
      de.addr = d_addr; de.wdata = d_wdata; de.wr = d_pwr; de.strb = d_strb;
      de.gap = cyc - d_end;
      dlog.push_back(de);
    end
    if (d_psel && d_pen && d_pready) d_end = cyc;
    if (d_psel && d_pen) d_acc++;
    if (d_lapv) d_lapv_n++;
    if (p_psel && !p_pen) begin
      pe.addr = p_addr; pe.wdata = p_wdata; pe.wr = p_pwr; pe.strb = p_strb;
      pe.gap = cyc - p_end;
      plog.push_back(pe);
    end
    if (p_psel && p_pen) p_end = cyc;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input bit pinst, input bit r, input bit l, input bit q, input logic [3:0] s);
    if (pinst) begin p_run = r; p_lap = l; p_lreq = q; p_sel = s; end
    else       begin d_run = r; d_lap = l; d_lreq = q; d_sel = s; end
    tick();
    p_run = 0; p_lap = 0; p_lreq = 0;
    d_run = 0; d_lap = 0; d_lreq = 0;
  endtask

  task automatic wait_idle(input bit pinst);
    int n;
    n = 0;
    do begin tick(); n++; end while ((pinst ? p_busy : d_busy) && n < 300);
    chk("idle_wait", pinst ? p_busy : d_busy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  int vcyc[3];

  initial begin
    // reset state
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_psel", d_psel, 0);
    chk("rst_pen", d_pen, 0);
    chk("rst_addr", d_addr, 0);
    chk("rst_busy", d_busy, 0);
    chk("rst_running", d_running, 0);
    chk("rst_err", d_err, 0);
    chk("rst_dispv", p_dispv, 0);
    chk("rst_ppsel", p_psel, 0);
    rst_n = 1'b1;

    // periodic CURR polls every 20 cycles with incrementing data
    for (int k = 0; k < 3; k++) begin
      int n;
      n = 0;
      do begin tick(); n++; end while (!p_dispv && n < 100);
      chk("poll_vld", p_dispv, 1);
      chk("poll_data", p_disp, 32'h100 + k);
      vcyc[k] = cyc;
    end
    chk("poll_period1", vcyc[1] - vcyc[0], 20);
    chk("poll_period2", vcyc[2] - vcyc[1], 20);
    chk("poll_cnt", plog.size(), 3);
    if (plog.size() > 0) begin
      chk("poll_addr", plog[0].addr, 16'h0004);
      chk("poll_wr", plog[0].wr, 0);
    end

    // RUN+LAP+LAPRD pulses on the same edge as a poll tick
    repeat (16) tick();
    plog.delete();
    pulse(1, 1, 1, 1, 4'd5);
    wait_idle(1);
    chk("arb_cnt", plog.size(), 4);
    if (plog.size() == 4) begin
      chk("arb0_addr", plog[0].addr, 16'h0000);
      chk("arb0_wdata", plog[0].wdata, 32'h1);
      chk("arb1_addr", plog[1].addr, 16'h0000);
      chk("arb1_wdata", plog[1].wdata, 32'h8);
      chk("arb2_addr", plog[2].addr, 16'h0024);
      chk("arb2_wr", plog[2].wr, 0);
      chk("arb3_addr", plog[3].addr, 16'h0004);
      for (int i = 1; i < 4; i++) chk("arb_gap", plog[i].gap >= 2, 1);
    end

    // first RUN pulse: exact SETUP/ACCESS timing
    pulse(0, 1, 0, 0, 4'd0);
    chk("t1_psel_k", d_psel, 0);
    chk("t1_busy_k", d_busy, 1);
    tick();
    chk("t1_setup_psel", d_psel, 1);
    chk("t1_setup_pen", d_pen, 0);
    chk("t1_setup_addr", d_addr, 16'h0000);
    chk("t1_setup_wdata", d_wdata, 32'h1);
    chk("t1_setup_strb", d_strb, 4'hF);
    chk("t1_setup_wr", d_pwr, 1);
    tick();
    chk("t1_acc_psel", d_psel, 1);
    chk("t1_acc_pen", d_pen, 1);
    chk("t1_acc_wdata", d_wdata, 32'h1);
    tick();
    chk("t1_done_psel", d_psel, 0);
    chk("t1_running", d_running, 1);

    // second RUN pulse: STOP
    dlog.delete();
    pulse(0, 1, 0, 0, 4'd0);
    wait_idle(0);
    chk("t2_cnt", dlog.size(), 1);
    if (dlog.size() == 1) chk("t2_wdata", dlog[0].wdata, 32'h2);
    chk("t2_running", d_running, 0);

    // LAP while running -> STORE, while stopped -> RESET
    pulse(0, 1, 0, 0, 4'd0);
    wait_idle(0);
    chk("t3_running", d_running, 1);
    dlog.delete();
    pulse(0, 0, 1, 0, 4'd0);
    wait_idle(0);
    chk("t3_cnt", dlog.size(), 1);
    if (dlog.size() == 1) begin
      chk("t3_store_addr", dlog[0].addr, 16'h0000);
      chk("t3_store_wdata", dlog[0].wdata, 32'h8);
      chk("t3_store_strb", dlog[0].strb, 4'hF);
    end
    pulse(0, 1, 0, 0, 4'd0);
    wait_idle(0);
    dlog.delete();
    pulse(0, 0, 1, 0, 4'd0);
    wait_idle(0);
    if (dlog.size() == 1) chk("t3_reset_wdata", dlog[0].wdata, 32'h4);
    else chk("t3_reset_cnt", dlog.size(), 1);
    chk("t3_running_off", d_running, 0);

    // lap read with 3 wait states
    d_wait = 3; d_rdata = 32'h0001_2345; d_lapv_n = 0; d_acc = 0;
    dlog.delete();
    pulse(0, 0, 0, 1, 4'd3);
    wait_idle(0);
    chk("t4_cnt", dlog.size(), 1);
    if (dlog.size() == 1) begin
      chk("t4_addr", dlog[0].addr, 16'h001C);
      chk("t4_wr", dlog[0].wr, 0);
      chk("t4_strb", dlog[0].strb, 4'h0);
      chk("t4_wdata", dlog[0].wdata, 32'h0);
    end
    chk("t4_acc_cycles", d_acc, 4);
    chk("t4_lap_data", d_lapdat, 32'h0001_2345);
    chk("t4_lapv_pulses", d_lapv_n, 1);
    chk("t4_err", d_err, 0);

    // out-of-range lap index: error, no transfer
    d_wait = 0;
    dlog.delete();
    pulse(0, 0, 0, 1, 4'd12);
    repeat (5) tick();
    chk("t5_err", d_err, 1);
    chk("t5_cnt", dlog.size(), 0);
    chk("t5_busy", d_busy, 0);

    // slave never ready: timeout after 64 ACCESS cycles
    do_reset();
    chk("t6_err_clr", d_err, 0);
    d_hang = 1; d_acc = 0;
    pulse(0, 1, 0, 0, 4'd0);
    wait_idle(0);
    chk("t6_acc_cycles", d_acc, 64);
    chk("t6_err", d_err, 1);
    chk("t6_running", d_running, 0);
    chk("t6_psel", d_psel, 0);
    d_hang = 0;

    // slave error on RUN write: state unchanged, error set
    do_reset();
    d_serr = 1;
    pulse(0, 1, 0, 0, 4'd0);
    wait_idle(0);
    chk("t7_running", d_running, 0);
    chk("t7_err", d_err, 1);
    d_serr = 0;

    // reset mid-ACCESS drops the bus asynchronously
    do_reset();
    d_hang = 1;
    pulse(0, 1, 0, 0, 4'd0);
    tick();
    tick();
    chk("t8_in_access", d_pen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_psel_async", d_psel, 0);
    chk("t8_pen_async", d_pen, 0);
    tick();
    rst_n = 1'b1;
    d_hang = 0;
    repeat (3) tick();
    chk("t8_psel_after", d_psel, 0);
    chk("t8_busy_after", d_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
